// File: rtl/pmbus_init_sequencer.sv
// pmbus_init_sequencer
// Power-up sequencer placed in front of the PMBus init block. It debounces the
// rail power-good, waits a settle delay and fires a one-cycle start pulse. It
// then watches SCL for the init burst to begin and go quiet. It reports
// done/error, and retries a bounded number of times on timeout.
module pmbus_init_sequencer #(
    parameter int PG_DEBOUNCE  = 1000,
    parameter int START_DELAY  = 50000,
    parameter int QUIET_CYCLES = 2048,
    parameter int TIMEOUT      = 2000000,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_BW       = 22,
    parameter int RT_BW        = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             power_good,
    input  logic             scl_mon,
    input  logic             rearm,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [RT_BW-1:0] retry_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_FIRE,
        S_WAIT_ACT,
        S_WAIT_QUIET,
        S_DONE,
        S_FAIL
    } state_t;

    // Terminal compare values; each counter leaves its state on reaching these,
    // so none of them can wrap.
    localparam logic [CNT_BW-1:0] PG_LAST = CNT_BW'(PG_DEBOUNCE - 1);
    localparam logic [CNT_BW-1:0] SD_LAST = CNT_BW'(START_DELAY - 1);
    localparam logic [CNT_BW-1:0] QT_LAST = CNT_BW'(QUIET_CYCLES - 1);
    localparam logic [CNT_BW-1:0] TO_LAST = CNT_BW'(TIMEOUT - 1);
    localparam logic [RT_BW-1:0]  RT_MAX  = RT_BW'(MAX_RETRY);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_BW-1:0] r_cnt;
    logic [CNT_BW-1:0] w_cnt_nxt;
    logic [CNT_BW-1:0] r_qcnt;
    logic [CNT_BW-1:0] w_qcnt_nxt;
    logic [RT_BW-1:0]  r_retry;
    logic [RT_BW-1:0]  w_retry_nxt;
    logic              r_pg_meta;
    logic              r_pg_s;
    logic              r_scl_meta;
    logic              r_scl_s;
    logic              r_start;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic              w_in_busy;
    logic              w_timeout;

    // Two-flop synchronizers. They are preset to the inactive levels: power
    // absent and SCL idle-high.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pg_meta  <= 1'b0;
            r_pg_s     <= 1'b0;
            r_scl_meta <= 1'b1;
            r_scl_s    <= 1'b1;
        end else begin
            r_pg_meta  <= power_good;
            r_pg_s     <= r_pg_meta;
            r_scl_meta <= scl_mon;
            r_scl_s    <= r_scl_meta;
        end
    end

    assign w_in_busy = (r_state == S_DELAY) || (r_state == S_FIRE) ||
                       (r_state == S_WAIT_ACT) || (r_state == S_WAIT_QUIET);
    assign w_timeout = (r_cnt == TO_LAST);

    // Next-state and counter logic. Loss of power-good in an active state
    // overrides everything. In WAIT_QUIET, completion beats timeout.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_qcnt_nxt  = r_qcnt;
        w_retry_nxt = r_retry;
        if (w_in_busy && !r_pg_s) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_qcnt_nxt  = '0;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_qcnt_nxt  = '0;
                    w_retry_nxt = '0;
                    if (!r_pg_s) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt == PG_LAST) begin
                        w_state_nxt = S_DELAY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_BW'(1);
                    end
                end
                S_DELAY: begin
                    if (r_cnt == SD_LAST) begin
                        w_state_nxt = S_FIRE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_BW'(1);
                    end
                end
                S_FIRE: begin
                    w_state_nxt = S_WAIT_ACT;
                    w_cnt_nxt   = '0;
                    w_qcnt_nxt  = '0;
                end
                S_WAIT_ACT, S_WAIT_QUIET: begin
                    if (r_state == S_WAIT_QUIET && r_scl_s && r_qcnt == QT_LAST) begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = '0;
                        w_qcnt_nxt  = '0;
                    end else if (w_timeout) begin
                        w_cnt_nxt  = '0;
                        w_qcnt_nxt = '0;
                        if (r_retry < RT_MAX) begin
                            w_retry_nxt = r_retry + RT_BW'(1);
                            w_state_nxt = S_DELAY;
                        end else begin
                            w_state_nxt = S_FAIL;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_BW'(1);
                        if (r_state == S_WAIT_ACT) begin
                            w_qcnt_nxt = '0;
                            if (!r_scl_s) begin
                                w_state_nxt = S_WAIT_QUIET;
                            end
                        end else begin
                            w_qcnt_nxt = r_scl_s ? (r_qcnt + CNT_BW'(1)) : '0;
                        end
                    end
                end
                S_DONE, S_FAIL: begin
                    if (rearm || !r_pg_s) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_qcnt_nxt  = '0;
                        w_retry_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_qcnt_nxt  = '0;
                    w_retry_nxt = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs. The outputs are decoded from the
    // next state, so they line up with the state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_qcnt  <= '0;
            r_retry <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_qcnt  <= w_qcnt_nxt;
            r_retry <= w_retry_nxt;
            r_start <= (w_state_nxt == S_FIRE);
            r_busy  <= (w_state_nxt == S_DELAY) || (w_state_nxt == S_FIRE) ||
                       (w_state_nxt == S_WAIT_ACT) || (w_state_nxt == S_WAIT_QUIET);
            r_done  <= (w_state_nxt == S_DONE);
            r_error <= (w_state_nxt == S_FAIL);
        end
    end

    assign start       = r_start;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign retry_count = r_retry;

endmodule

// File: tb/tb_pmbus_init_sequencer.sv
// Testbench for pmbus_init_sequencer with small timing parameters.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_pmbus_init_sequencer;

    logic       clock;
    logic       reset;
    logic       power_good;
    logic       scl_mon;
    logic       rearm;
    logic       start;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] retry_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       pg;
        logic       scl;
        logic       rm;
        int         cyc;
        logic       e_start;
        logic       e_busy;
        logic       e_done;
        logic       e_error;
        logic [1:0] e_retry;
    } vec_t;

    vec_t vecs[$];

    pmbus_init_sequencer #(
        .PG_DEBOUNCE (4),
        .START_DELAY (8),
        .QUIET_CYCLES(5),
        .TIMEOUT     (40),
        .MAX_RETRY   (2),
        .CNT_BW      (22),
        .RT_BW       (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .power_good (power_good),
        .scl_mon    (scl_mon),
        .rearm      (rearm),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .retry_count(retry_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stop a hung run with a failure line rather than spinning forever.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic s, input logic b,
                              input logic d, input logic e, input logic [1:0] r);
        check({tag, "_start"}, 32'(start), 32'(s));
        check({tag, "_busy"},  32'(busy),  32'(b));
        check({tag, "_done"},  32'(done),  32'(d));
        check({tag, "_error"}, 32'(error), 32'(e));
        check({tag, "_retry"}, 32'(retry_count), 32'(r));
    endtask

    task automatic add(input logic pg, input logic scl, input logic rm, input int cyc,
                       input logic s, input logic b, input logic d, input logic e,
                       input logic [1:0] r);
        vec_t v;
        v.pg = pg; v.scl = scl; v.rm = rm; v.cyc = cyc;
        v.e_start = s; v.e_busy = b; v.e_done = d; v.e_error = e; v.e_retry = r;
        vecs.push_back(v);
    endtask

    // Hold reset for two cycles, check the reset values, then release on a
    // falling edge. The caller drives stimulus from that same edge.
    task automatic do_reset(input string tag);
        reset      = 1'b1;
        power_good = 1'b0;
        scl_mon    = 1'b1;
        rearm      = 1'b0;
        repeat (2) @(negedge clock);
        check_outs(tag, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
    endtask

    // Cycles until start is next seen high. A return of -1 means the budget ran out.
    task automatic find_start(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clock);
            if (start) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic count_starts(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (start) cnt++;
        end
    endtask

    initial begin
        int c;
        reset      = 1'b1;
        power_good = 1'b0;
        scl_mon    = 1'b1;
        rearm      = 1'b0;
        do_reset("reset");

        // Nominal sequence, then rearm from DONE and a second start pulse.
        // Cycle numbers count falling edges from the reset release (N0).
        add(1, 1, 0, 5, 0, 0, 0, 0, 0);  // N5: debounce not yet passed
        add(1, 1, 0, 1, 0, 1, 0, 0, 0);  // N6: DELAY
        add(1, 1, 0, 7, 0, 1, 0, 0, 0);  // N13: last DELAY cycle
        add(1, 1, 0, 1, 1, 1, 0, 0, 0);  // N14: FIRE, 4+8+2 after power_good
        add(1, 1, 0, 1, 0, 1, 0, 0, 0);  // N15: single-cycle pulse
        add(1, 1, 0, 2, 0, 1, 0, 0, 0);  // N17: toggling starts 3 after start
        for (int i = 0; i < 10; i++) begin
            add(1, logic'(i % 2), 0, 1, 0, 1, 0, 0, 0);  // last low driven at N25
        end
        add(1, 1, 0, 5, 0, 1, 0, 0, 0);  // N32: one quiet cycle short
        add(1, 1, 0, 1, 0, 0, 1, 0, 0);  // N33: DONE
        add(1, 1, 1, 1, 0, 0, 0, 0, 0);  // N34: rearm back to IDLE
        add(1, 1, 0, 3, 0, 0, 0, 0, 0);  // N37: re-debouncing
        add(1, 1, 0, 1, 0, 1, 0, 0, 0);  // N38: DELAY again
        add(1, 1, 0, 8, 1, 1, 0, 0, 0);  // N46: second start pulse

        for (int i = 0; i < vecs.size(); i++) begin
            power_good = vecs[i].pg;
            scl_mon    = vecs[i].scl;
            rearm      = vecs[i].rm;
            repeat (vecs[i].cyc) @(negedge clock);
            check_outs($sformatf("vec%0d", i), vecs[i].e_start, vecs[i].e_busy,
                       vecs[i].e_done, vecs[i].e_error, vecs[i].e_retry);
        end

        // Reset during the start cycle must drop start at once.
        reset = 1'b1;
        #1;
        check_outs("rst_on_start", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Debounce glitch: 3 high, 1 low, then high. The count restarts after the glitch.
        do_reset("reset_glitch");
        power_good = 1'b1;
        repeat (3) @(negedge clock);
        power_good = 1'b0;
        @(negedge clock);
        power_good = 1'b1;
        repeat (2) @(negedge clock);
        check("glitch_busy_n6", 32'(busy), 32'd0);
        repeat (3) @(negedge clock);
        check("glitch_busy_n9", 32'(busy), 32'd0);
        @(negedge clock);
        check("glitch_busy_n10", 32'(busy), 32'd1);
        find_start(30, c);
        check("glitch_start_gap", 32'(c), 32'd8);

        // No SCL activity: three attempts 49 cycles apart, then FAIL.
        do_reset("reset_noact");
        power_good = 1'b1;
        find_start(40, c);
        check("noact_first_start", 32'(c), 32'd14);
        find_start(80, c);
        check("noact_gap1", 32'(c), 32'd49);
        check("noact_retry1", 32'(retry_count), 32'd1);
        find_start(80, c);
        check("noact_gap2", 32'(c), 32'd49);
        check("noact_retry2", 32'(retry_count), 32'd2);
        repeat (40) @(negedge clock);
        check_outs("noact_pre_fail", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        @(negedge clock);
        check_outs("noact_fail", 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        count_starts(20, c);
        check("noact_no_more_starts", 32'(c), 32'd0);

        // SCL stuck low after the first start: same retry timing, ends in FAIL.
        do_reset("reset_stuck");
        power_good = 1'b1;
        find_start(40, c);
        check("stuck_first_start", 32'(c), 32'd14);
        scl_mon = 1'b0;
        find_start(80, c);
        check("stuck_gap1", 32'(c), 32'd49);
        check("stuck_retry1", 32'(retry_count), 32'd1);
        find_start(80, c);
        check("stuck_gap2", 32'(c), 32'd49);
        repeat (41) @(negedge clock);
        check_outs("stuck_fail", 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);

        // Abort: power_good drops in WAIT_QUIET. The abort lands one cycle before completion would.
        do_reset("reset_abort");
        power_good = 1'b1;
        find_start(40, c);
        check("abort_first_start", 32'(c), 32'd14);
        @(negedge clock);
        scl_mon = 1'b0;
        @(negedge clock);
        scl_mon = 1'b1;
        repeat (3) @(negedge clock);
        power_good = 1'b0;
        check("abort_busy_before", 32'(busy), 32'd1);
        repeat (3) @(negedge clock);
        check_outs("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        count_starts(60, c);
        check("abort_no_more_starts", 32'(c), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
